// File: rtl/ldm_stm_pkg.sv
// Shared types and constants for the LDM/STM multi-register transfer sequencer.
package ldm_stm_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned NUM_REGS   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RDREG,
    ST_REQ,
    ST_WAIT,
    ST_WB,
    ST_DONE
  } state_t;

  // Addressing mode encoded directly as {up, pre}
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_DB = 2'b01,
    MODE_IA = 2'b10,
    MODE_IB = 2'b11
  } addr_mode_t;

  function automatic addr_mode_t addr_mode(input logic up, input logic pre);
    return addr_mode_t'({up, pre});
  endfunction

endpackage

// File: rtl/ldm_stm_sequencer_reg_list_pick.sv
// Lowest-set-bit encoder over the working mask, plus popcount of the command list.
module reg_list_pick
  import ldm_stm_pkg::*;
(
  input  logic [NUM_REGS-1:0] mask,
  input  logic [NUM_REGS-1:0] list,
  output logic [3:0]          idx,
  output logic                any,
  output logic [4:0]          count
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = NUM_REGS; i > 0; i--) begin
      if (mask[i-1]) begin
        idx = 4'(i - 1);
        any = 1'b1;
      end
    end
  end

  // Number of registers selected by the incoming list
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      count = count + 5'(list[i]);
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks a 16-bit register list issuing one word memory
// request per selected register, optionally writing the new base back.
// Optional feature macro: LDM_STM_WRITEBACK_EN enables the base writeback state.
module ldm_stm_sequencer
  import ldm_stm_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       reg_list,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [3:0]        base_reg,
  input  logic              load,
  input  logic              up,
  input  logic              pre,
  input  logic              writeback,
  output logic              busy,
  output logic              done,
  output logic [3:0]        rf_read_reg,
  input  logic [31:0]       rf_read_data,
  output logic              rf_write_en,
  output logic [3:0]        rf_write_reg,
  output logic [31:0]       rf_write_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data
);

  localparam logic [ADDR_W-1:0] WORD = ADDR_W'(WORD_BYTES);

  state_t            state, state_next;
  logic [15:0]       mask;
  logic [15:0]       mask_cleared;
  logic [ADDR_W-1:0] addr;
  logic              load_q;
  logic [3:0]        idx, idx_q;
  logic              any;
  logic [4:0]        count;
  logic              req_first;
  logic [31:0]       wdata_q;
  logic              rf_we_q;
  logic [3:0]        rf_wreg_q;
  logic [31:0]       rf_wdata_q;
  logic              wb_go;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] n_bytes;
  logic [ADDR_W-1:0] start_addr;

`ifdef LDM_STM_WRITEBACK_EN
  logic              wb_q;
  logic [ADDR_W-1:0] final_base;
  logic [3:0]        base_reg_q;
  assign wb_go = wb_q;
`else
  logic unused_wb_inputs;
  assign unused_wb_inputs = ^{writeback, base_reg};
  assign wb_go = 1'b0;
`endif

  reg_list_pick u_pick (
    .mask  (mask),
    .list  (reg_list),
    .idx   (idx),
    .any   (any),
    .count (count)
  );

  assign base         = {base_addr[ADDR_W-1:2], 2'b00};
  assign n_bytes      = ADDR_W'({count, 2'b00});
  assign mask_cleared = mask & ~(16'd1 << idx);

  // First transfer address for the four addressing modes
  always_comb begin
    case (addr_mode(up, pre))
      MODE_IA: start_addr = base;
      MODE_IB: start_addr = base + WORD;
      MODE_DA: start_addr = base - n_bytes + WORD;
      default: start_addr = base - n_bytes;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; an empty list settles one cycle in RDREG before DONE
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) state_next = (count == '0 || !load) ? ST_RDREG : ST_REQ;
      end
      ST_RDREG: state_next = any ? ST_REQ : ST_DONE;
      ST_REQ: begin
        if (mem_req_ready) begin
          if (load_q)                 state_next = ST_WAIT;
          else if (mask_cleared != '0) state_next = ST_RDREG;
          else                        state_next = wb_go ? ST_WB : ST_DONE;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) state_next = any ? ST_REQ : (wb_go ? ST_WB : ST_DONE);
      end
      ST_WB:   state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Command latch, mask/address walk, store data capture and registered rf writes
  always_ff @(posedge clk) begin
    if (reset) begin
      mask       <= '0;
      addr       <= '0;
      load_q     <= 1'b0;
      idx_q      <= '0;
      req_first  <= 1'b0;
      wdata_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_wreg_q  <= '0;
      rf_wdata_q <= '0;
`ifdef LDM_STM_WRITEBACK_EN
      wb_q       <= 1'b0;
      final_base <= '0;
      base_reg_q <= '0;
`endif
    end else begin
      rf_we_q   <= 1'b0;
      req_first <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mask   <= reg_list;
            addr   <= start_addr;
            load_q <= load;
`ifdef LDM_STM_WRITEBACK_EN
            wb_q       <= writeback && !(load && reg_list[base_reg]) && (count != '0);
            final_base <= up ? (base + n_bytes) : (base - n_bytes);
            base_reg_q <= base_reg;
`endif
          end
        end
        ST_RDREG: req_first <= any;
        ST_REQ: begin
          // Read data arrives during the first REQ cycle; hold it from then on
          if (req_first) wdata_q <= rf_read_data;
          if (mem_req_ready) begin
            mask  <= mask_cleared;
            addr  <= addr + WORD;
            idx_q <= idx;
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            rf_we_q    <= 1'b1;
            rf_wreg_q  <= idx_q;
            rf_wdata_q <= mem_rsp_data;
          end
        end
`ifdef LDM_STM_WRITEBACK_EN
        ST_WB: begin
          rf_we_q    <= 1'b1;
          rf_wreg_q  <= base_reg_q;
          rf_wdata_q <= 32'(final_base);
        end
`endif
        default: ;
      endcase
    end
  end

  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);
  assign rf_read_reg   = idx;
  assign rf_write_en   = rf_we_q;
  assign rf_write_reg  = rf_wreg_q;
  assign rf_write_data = rf_wdata_q;
  assign mem_req_valid = (state == ST_REQ);
  assign mem_we        = (state == ST_REQ) && !load_q;
  assign mem_addr      = addr;
  assign mem_wdata     = req_first ? rf_read_data : wdata_q;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed self-checking bench for ldm_stm_sequencer.
module tb_ldm_stm_sequencer;

  localparam int ADDR_W = 32;
`ifdef LDM_STM_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [15:0]       reg_list;
  logic [ADDR_W-1:0] base_addr;
  logic [3:0]        base_reg;
  logic              load, up, pre, writeback;
  logic              busy, done;
  logic [3:0]        rf_read_reg;
  logic [31:0]       rf_read_data;
  logic              rf_write_en;
  logic [3:0]        rf_write_reg;
  logic [31:0]       rf_write_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rsp_data;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] rf_regs [16];

  logic [31:0] st_addr [64];
  logic [31:0] st_data [64];
  logic [31:0] ld_addr [64];
  logic [3:0]  wr_reg  [64];
  logic [31:0] wr_data [64];
  int unsigned st_cnt = 0;
  int unsigned ld_cnt = 0;
  int unsigned wr_cnt = 0;

  ldm_stm_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .reg_list      (reg_list),
    .base_addr     (base_addr),
    .base_reg      (base_reg),
    .load          (load),
    .up            (up),
    .pre           (pre),
    .writeback     (writeback),
    .busy          (busy),
    .done          (done),
    .rf_read_reg   (rf_read_reg),
    .rf_read_data  (rf_read_data),
    .rf_write_en   (rf_write_en),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data)
  );

  always #5 clk = ~clk;

  // Register file spare read port: data one cycle after the index
  always @(posedge clk) rf_read_data <= rf_regs[rf_read_reg];

  // Memory: load response the cycle after acceptance, data = addr ^ 0x5A5A0000
  always @(posedge clk) begin
    if (reset) begin
      mem_rsp_valid <= 1'b0;
      mem_rsp_data  <= '0;
    end else begin
      mem_rsp_valid <= 1'b0;
      if (mem_req_valid && mem_req_ready && !mem_we) begin
        mem_rsp_valid <= 1'b1;
        mem_rsp_data  <= mem_addr ^ 32'h5A5A_0000;
      end
    end
  end

  // Transaction logger
  always @(posedge clk) begin
    if (!reset) begin
      if (mem_req_valid && mem_req_ready) begin
        if (mem_we) begin
          if (st_cnt < 64) begin
            st_addr[st_cnt] <= mem_addr;
            st_data[st_cnt] <= mem_wdata;
          end
          st_cnt <= st_cnt + 1;
        end else begin
          if (ld_cnt < 64) ld_addr[ld_cnt] <= mem_addr;
          ld_cnt <= ld_cnt + 1;
        end
      end
      if (rf_write_en) begin
        if (wr_cnt < 64) begin
          wr_reg[wr_cnt]  <= rf_write_reg;
          wr_data[wr_cnt] <= rf_write_data;
        end
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 500000", $time);
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [15:0] l, input logic [31:0] b, input logic [3:0] br,
                       input logic ld, input logic u, input logic p, input logic wb);
    @(negedge clk);
    reg_list  = l;
    base_addr = b;
    base_reg  = br;
    load      = ld;
    up        = u;
    pre       = p;
    writeback = wb;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    reg_list  = 16'hFFFF;
    base_addr = 32'hDEAD_BEEF;
    base_reg  = ~br;
    load      = ~ld;
    up        = ~u;
    pre       = ~p;
    writeback = ~wb;
  endtask

  // Returns the cycle (counted from start = 0) in which done is seen
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, rf_write_en, mem_req_valid, mem_we} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 00000", {busy, done, rf_write_en, mem_req_valid, mem_we});
    end
    n_checks++;
    if ({rf_read_reg, rf_write_reg, rf_write_data, mem_addr, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h %h required all 0",
               rf_read_reg, rf_write_reg, rf_write_data, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stm_ia;
    int unsigned s0, w0, l0;
    int cyc;
    logic [31:0] ea [3];
    logic [31:0] ed [3];
    ea = '{32'h1000, 32'h1004, 32'h1008};
    ed = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0004};
    s0 = st_cnt; w0 = wr_cnt; l0 = ld_cnt;
    issue(16'h0013, 32'h1000, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL stm_busy_rise: got %b required 1", busy); end
    wait_done(cyc);
    n_checks++;
    if (cyc !== 7) begin n_fail++; $display("FAIL stm_done_cycle: got %0d required 7", cyc); end
    @(negedge clk);
    n_checks++;
    if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL stm_done_pulse: got done,busy=%b required 00", {done, busy}); end
    n_checks++;
    if (st_cnt - s0 !== 3) begin n_fail++; $display("FAIL stm_store_count: got %0d required 3", st_cnt - s0); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({st_addr[s0+i], st_data[s0+i]} !== {ea[i], ed[i]}) begin
        n_fail++;
        $display("FAIL stm_store%0d: got %h/%h required %h/%h", i, st_addr[s0+i], st_data[s0+i], ea[i], ed[i]);
      end
    end
    n_checks++;
    if ((wr_cnt - w0) + (ld_cnt - l0) !== 0) begin
      n_fail++;
      $display("FAIL stm_no_rf_or_load: got %0d writes %0d loads required 0", wr_cnt - w0, ld_cnt - l0);
    end
  endtask

  task automatic test_ldm_db_wb;
    int unsigned l0, w0, nw;
    int cyc;
    logic [31:0] ea [3];
    logic [3:0]  er [4];
    logic [31:0] ed [4];
    ea = '{32'h1FF4, 32'h1FF8, 32'h1FFC};
    er = '{4'd1, 4'd2, 4'd15, 4'd13};
    ed = '{32'h5A5A_1FF4, 32'h5A5A_1FF8, 32'h5A5A_1FFC, 32'h0000_1FF4};
    nw = WB_EN ? 4 : 3;
    l0 = ld_cnt; w0 = wr_cnt;
    issue(16'h8006, 32'h2000, 4'd13, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_done(cyc);
    n_checks++;
    if (cyc !== (WB_EN ? 8 : 7)) begin n_fail++; $display("FAIL ldm_done_cycle: got %0d required %0d", cyc, WB_EN ? 8 : 7); end
    @(negedge clk);
    n_checks++;
    if (ld_cnt - l0 !== 3) begin n_fail++; $display("FAIL ldm_load_count: got %0d required 3", ld_cnt - l0); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ld_addr[l0+i] !== ea[i]) begin
        n_fail++;
        $display("FAIL ldm_addr%0d: got %h required %h", i, ld_addr[l0+i], ea[i]);
      end
    end
    n_checks++;
    if (wr_cnt - w0 !== nw) begin n_fail++; $display("FAIL ldm_write_count: got %0d required %0d", wr_cnt - w0, nw); end
    for (int i = 0; i < nw; i++) begin
      n_checks++;
      if ({wr_reg[w0+i], wr_data[w0+i]} !== {er[i], ed[i]}) begin
        n_fail++;
        $display("FAIL ldm_write%0d: got R%0d=%h required R%0d=%h", i, wr_reg[w0+i], wr_data[w0+i], er[i], ed[i]);
      end
    end
  endtask

  task automatic test_ldm_base_in_list;
    int unsigned w0;
    int cyc;
    logic [3:0]  er [2];
    logic [31:0] ed [2];
    er = '{4'd0, 4'd3};
    ed = '{32'h5A5A_3000, 32'h5A5A_3004};
    w0 = wr_cnt;
    issue(16'h0009, 32'h3000, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 5) begin n_fail++; $display("FAIL base_in_list_done_cycle: got %0d required 5", cyc); end
    @(negedge clk);
    n_checks++;
    if (wr_cnt - w0 !== 2) begin n_fail++; $display("FAIL base_in_list_write_count: got %0d required 2", wr_cnt - w0); end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({wr_reg[w0+i], wr_data[w0+i]} !== {er[i], ed[i]}) begin
        n_fail++;
        $display("FAIL base_in_list_write%0d: got R%0d=%h required R%0d=%h", i, wr_reg[w0+i], wr_data[w0+i], er[i], ed[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int unsigned s0, l0;
    int k;
    int cyc;
    s0 = st_cnt; l0 = ld_cnt;
    issue(16'h0006, 32'h4001, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    k = 0;
    while (!((st_cnt - s0) == 1 && mem_req_valid) && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 20) begin n_fail++; $display("FAIL bp_second_req: got timeout after %0d cycles required request", k); end
    mem_req_ready = 1'b0;
    start         = 1'b1;
    reg_list      = 16'h0001;
    load          = 1'b1;
    for (int j = 0; j < 5; j++) begin
      n_checks++;
      if ({mem_req_valid, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h4008, 32'hA000_0002}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b we=%b a=%h d=%h required 1 1 00004008 a0000002",
                 j, mem_req_valid, mem_we, mem_addr, mem_wdata);
      end
      if (j == 4) begin
        mem_req_ready = 1'b1;
        start         = 1'b0;
      end
      @(negedge clk);
    end
    wait_done(cyc);
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b required 1", done); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_start_ignored_busy: got %b required 0", busy); end
    n_checks++;
    if ({st_cnt - s0, ld_cnt - l0} !== {32'd2, 32'd0}) begin
      n_fail++;
      $display("FAIL bp_counts: got %0d stores %0d loads required 2 0", st_cnt - s0, ld_cnt - l0);
    end
    n_checks++;
    if ({st_addr[s0], st_data[s0]} !== {32'h4004, 32'hA000_0001}) begin
      n_fail++;
      $display("FAIL bp_store0: got %h/%h required 00004004/a0000001", st_addr[s0], st_data[s0]);
    end
  endtask

  task automatic test_empty;
    int unsigned s0, l0, w0;
    int cyc;
    s0 = st_cnt; l0 = ld_cnt; w0 = wr_cnt;
    issue(16'h0000, 32'h7000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if ({busy, mem_req_valid} !== 2'b10) begin n_fail++; $display("FAIL empty_cycle1: got busy,valid=%b required 10", {busy, mem_req_valid}); end
    wait_done(cyc);
    n_checks++;
    if (cyc !== 2) begin n_fail++; $display("FAIL empty_done_cycle: got %0d required 2", cyc); end
    repeat (2) @(negedge clk);
    n_checks++;
    if ((st_cnt - s0) + (ld_cnt - l0) + (wr_cnt - w0) !== 0) begin
      n_fail++;
      $display("FAIL empty_activity: got %0d/%0d/%0d required 0/0/0", st_cnt - s0, ld_cnt - l0, wr_cnt - w0);
    end
  endtask

  task automatic test_reset_mid_ldm;
    int unsigned w0, l0, nw;
    int cyc;
    logic [3:0]  er [2];
    logic [31:0] ed [2];
    er = '{4'd5, 4'd0};
    ed = '{32'h5A5A_6000, 32'h0000_5FFC};
    nw = WB_EN ? 2 : 1;
    w0 = wr_cnt;
    issue(16'h0003, 32'h5000, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({busy, mem_req_valid, mem_rsp_valid} !== 3'b101) begin
      n_fail++;
      $display("FAIL midreset_in_wait: got busy,valid,rsp=%b required 101", {busy, mem_req_valid, mem_rsp_valid});
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, rf_write_en, mem_req_valid, mem_we} !== 5'b0) begin
      n_fail++;
      $display("FAIL midreset_ctrl: got %b required 00000", {busy, done, rf_write_en, mem_req_valid, mem_we});
    end
    n_checks++;
    if ({rf_read_reg, rf_write_reg, rf_write_data, mem_addr, mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL midreset_data: got %h %h %h %h %h required all 0",
               rf_read_reg, rf_write_reg, rf_write_data, mem_addr, mem_wdata);
    end
    reset = 1'b0;
    n_checks++;
    if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL midreset_no_write: got %0d required 0", wr_cnt - w0); end
    l0 = ld_cnt;
    issue(16'h0020, 32'h6003, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_done(cyc);
    n_checks++;
    if (cyc !== (WB_EN ? 4 : 3)) begin n_fail++; $display("FAIL after_reset_done_cycle: got %0d required %0d", cyc, WB_EN ? 4 : 3); end
    @(negedge clk);
    n_checks++;
    if ({ld_cnt - l0, ld_addr[l0]} !== {32'd1, 32'h6000}) begin
      n_fail++;
      $display("FAIL after_reset_load: got %0d loads addr %h required 1 at 00006000", ld_cnt - l0, ld_addr[l0]);
    end
    n_checks++;
    if (wr_cnt - w0 !== nw) begin n_fail++; $display("FAIL after_reset_write_count: got %0d required %0d", wr_cnt - w0, nw); end
    for (int i = 0; i < nw; i++) begin
      n_checks++;
      if ({wr_reg[w0+i], wr_data[w0+i]} !== {er[i], ed[i]}) begin
        n_fail++;
        $display("FAIL after_reset_write%0d: got R%0d=%h required R%0d=%h", i, wr_reg[w0+i], wr_data[w0+i], er[i], ed[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf_regs[i] = 32'hA000_0000 + 32'(i);
    reset         = 1'b1;
    start         = 1'b0;
    reg_list      = '0;
    base_addr     = '0;
    base_reg      = '0;
    load          = 1'b0;
    up            = 1'b1;
    pre           = 1'b0;
    writeback     = 1'b0;
    mem_req_ready = 1'b1;
    test_reset();
    test_stm_ia();
    test_ldm_db_wb();
    test_ldm_base_in_list();
    test_backpressure();
    test_empty();
    test_reset_mid_ldm();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
